// File: rtl/dmem_if.sv
// Load/store request/acknowledge bus between the CPU (master)
// and the data memory (slave).
interface dmem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        output wstrb,
        input  ack,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        input  wstrb,
        output ack,
        output rdata,
        output err
    );
endinterface

// File: rtl/dmem.sv
// Word-organised data memory with programmable wait states,
// byte-masked writes and misalign/range fault reporting.
module dmem #(
    parameter int ADDR_W = 8,
    parameter int WAIT   = 1
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);
    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [3:0] WAIT_C = 4'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        run_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        ack_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [DEPTH];

    logic              go_ack;
    logic              sel_live;
    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [31:0]       cur_wdata;
    logic [3:0]        cur_wstrb;
    logic              cur_fault;
    logic [ADDR_W-1:0] cur_idx;

    // With zero wait states the ACK entry edge is also the sampling
    // edge, so the live bus fields are used instead of the latched ones.
    assign sel_live  = (state_q == S_IDLE);
    assign cur_we    = sel_live ? bus.we    : we_q;
    assign cur_addr  = sel_live ? bus.addr  : addr_q;
    assign cur_wdata = sel_live ? bus.wdata : wdata_q;
    assign cur_wstrb = sel_live ? bus.wstrb : wstrb_q;
    assign cur_idx   = cur_addr[ADDR_W+1:2];
    assign cur_fault = (cur_addr[1:0] != 2'b00)
                     || (cur_addr[31:ADDR_W+2] != '0);

    always_comb begin
        go_ack = 1'b0;
        unique case (state_q)
            S_IDLE:  go_ack = run_q && bus.req && (WAIT_C == 4'd0);
            S_WAIT:  go_ack = (cnt_q == 4'd1);
            default: go_ack = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            run_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            run_q   <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            unique case (state_q)
                S_IDLE: begin
                    if (run_q && bus.req) begin
                        we_q    <= bus.we;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        wstrb_q <= bus.wstrb;
                        cnt_q   <= WAIT_C;
                        state_q <= (WAIT_C == 4'd0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACK: begin
                    cnt_q   <= 4'd0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if (go_ack) begin
                ack_q <= 1'b1;
                err_q <= cur_fault;
                if (!cur_we && !cur_fault) begin
                    rdata_q <= mem[cur_idx];
                end
            end
        end
    end

    // Contents survive reset; run_q keeps reset cycles from committing.
    always_ff @(posedge clk) begin
        if (go_ack && cur_we && !cur_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_wstrb[i]) begin
                    mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_dmem.sv
// Scoreboard bench for dmem: three instances with WAIT = 1, 0, 3
// driven one at a time and checked against a word-array model.
module tb_dmem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d   [3];
    logic        req_d   [3];
    logic        we_d    [3];
    logic [31:0] addr_d  [3];
    logic [31:0] wdata_d [3];
    logic [3:0]  wstrb_d [3];
    logic        ack_w   [3];
    logic [31:0] rdata_w [3];
    logic        err_w   [3];

    dmem_if if0 ();
    dmem_if if1 ();
    dmem_if if2 ();

    assign if0.req = req_d[0];
    assign if0.we = we_d[0];
    assign if0.addr = addr_d[0];
    assign if0.wdata = wdata_d[0];
    assign if0.wstrb = wstrb_d[0];
    assign if1.req = req_d[1];
    assign if1.we = we_d[1];
    assign if1.addr = addr_d[1];
    assign if1.wdata = wdata_d[1];
    assign if1.wstrb = wstrb_d[1];
    assign if2.req = req_d[2];
    assign if2.we = we_d[2];
    assign if2.addr = addr_d[2];
    assign if2.wdata = wdata_d[2];
    assign if2.wstrb = wstrb_d[2];
    assign ack_w[0] = if0.ack;
    assign ack_w[1] = if1.ack;
    assign ack_w[2] = if2.ack;
    assign rdata_w[0] = if0.rdata;
    assign rdata_w[1] = if1.rdata;
    assign rdata_w[2] = if2.rdata;
    assign err_w[0] = if0.err;
    assign err_w[1] = if1.err;
    assign err_w[2] = if2.err;

    dmem #(.ADDR_W(8), .WAIT(1)) u_dut0 (.clk(clk), .rst(rst_d[0]), .bus(if0));
    dmem #(.ADDR_W(8), .WAIT(0)) u_dut1 (.clk(clk), .rst(rst_d[1]), .bus(if1));
    dmem #(.ADDR_W(8), .WAIT(3)) u_dut2 (.clk(clk), .rst(rst_d[2]), .bus(if2));

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl [3][256];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wait_of(int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed view over a word array, 1 KiB in range.
    function automatic exp_t model(int d, bit w, logic [31:0] a,
                                   logic [31:0] wd, logic [3:0] st);
        exp_t e;
        int   wi;
        e.d = d;
        e.err = ((a % 4) != 0) || (a >= 32'd1024);
        e.chk_rd = !w;
        e.rdata = 32'd0;
        e.cyc = 0;
        if (!e.err) begin
            wi = int'(a / 4);
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (st[i]) mdl[d][wi][8*i +: 8] = wd[8*i +: 8];
            end else begin
                e.rdata = mdl[d][wi];
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ack_w[d] === 1'b1) begin
                if (sbq.size() == 0) begin
                    check($sformatf("unexpected_ack%0d", d), 32'(ack_w[d]), 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check($sformatf("ack_dut%0d", d), d, e.d);
                    check($sformatf("ack_cycle%0d", d), cyc, e.cyc);
                    check($sformatf("err%0d", d), 32'(err_w[d]), 32'(e.err));
                    if (e.chk_rd)
                        check($sformatf("rdata%0d", d), rdata_w[d], e.rdata);
                end
            end else begin
                check($sformatf("idle_out%0d", d),
                      rdata_w[d] | 32'(err_w[d]), 32'd0);
            end
        end
    end

    // Called just after a rising edge; returns just after the ACK exit edge
    // with req still high so the caller may chain another transaction.
    task automatic issue(int d, bit w, logic [31:0] a,
                         logic [31:0] wd, logic [3:0] st);
        exp_t e;
        int   t;
        req_d[d] = 1'b1;
        we_d[d] = w;
        addr_d[d] = a;
        wdata_d[d] = wd;
        wstrb_d[d] = st;
        e = model(d, w, a, wd, st);
        e.cyc = cyc + 1 + wait_of(d);
        sbq.push_back(e);
        t = 0;
        while (ack_w[d] !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (ack_w[d] !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout%0d: got no ack expected ack within 40", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int d, int gap);
        req_d[d] = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic random_phase(int d, int n);
        logic [31:0] a;
        int          wi;
        int          r;
        for (int i = 0; i < 16; i++) begin
            issue(d, 1'b1, 32'(i * 4), $urandom, 4'hF);
            idle(d, 1);
        end
        for (int i = 0; i < n; i++) begin
            wi = $urandom_range(0, 15);
            r = $urandom_range(0, 9);
            a = 32'(wi * 4);
            if (r == 0) a = a + 32'($urandom_range(1, 3));
            if (r == 1) a = a | (32'd1024 << $urandom_range(0, 21));
            issue(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
            if ($urandom_range(0, 1) == 1) idle(d, $urandom_range(0, 3));
        end
        idle(d, 2);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_d[d] = 1'b1;
            req_d[d] = 1'b0;
            we_d[d] = 1'b0;
            addr_d[d] = 32'd0;
            wdata_d[d] = 32'd0;
            wstrb_d[d] = 4'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_ack%0d", d), 32'(ack_w[d]), 32'd0);
            check($sformatf("rst_err%0d", d), 32'(err_w[d]), 32'd0);
            check($sformatf("rst_rdata%0d", d), rdata_w[d], 32'd0);
            rst_d[d] = 1'b0;
        end
        idle(0, 4);

        issue(0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF);
        idle(0, 1);
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        idle(0, 1);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        idle(0, 1);
        issue(0, 1'b1, 32'h10, 32'h11223344, 4'b0101);
        idle(0, 1);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
        idle(0, 1);
        check("model_lane_merge", mdl[0][4], 32'hDE22BE44);
        issue(0, 1'b0, 32'h12, 32'h0, 4'h0);
        idle(0, 1);
        issue(0, 1'b1, 32'h400, 32'h55555555, 4'hF);
        idle(0, 1);
        issue(0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(0, 1);
        issue(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
        idle(0, 1);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        idle(0, 2);
        random_phase(0, 60);

        issue(1, 1'b1, 32'h40, 32'h0BADF00D, 4'hF);
        issue(1, 1'b0, 32'h40, 32'h0, 4'h0);
        issue(1, 1'b1, 32'h40, 32'h600DCAFE, 4'b1100);
        issue(1, 1'b0, 32'h40, 32'h0, 4'h0);
        idle(1, 2);
        random_phase(1, 60);

        issue(2, 1'b1, 32'h20, 32'h12345678, 4'hF);
        idle(2, 2);
        req_d[2] = 1'b1;
        we_d[2] = 1'b1;
        addr_d[2] = 32'h20;
        wdata_d[2] = 32'hCAFEF00D;
        wstrb_d[2] = 4'hF;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_d[2] = 1'b1;
        #1;
        check("abort_ack", 32'(ack_w[2]), 32'd0);
        check("abort_err", 32'(err_w[2]), 32'd0);
        check("abort_rdata", rdata_w[2], 32'd0);
        req_d[2] = 1'b0;
        @(posedge clk);
        #1;
        rst_d[2] = 1'b0;
        idle(2, 8);
        issue(2, 1'b0, 32'h20, 32'h0, 4'h0);
        idle(2, 2);
        issue(2, 1'b1, 32'h24, 32'h89ABCDEF, 4'b0011);
        issue(2, 1'b0, 32'h24, 32'h0, 4'h0);
        idle(2, 4);

        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
